instr_issuer: RTL and testbench

Instruction issuer for the ALU datapath: holds a small loadable program store and feeds it, one 16-bit instruction at a time, into the datapath's decoder/control pair. It drives the `Instr`/`START` side of the `START`/`RDY` handshake and waits for each instruction to complete before issuing the next. It sits at the top of the datapath and replaces testbench-driven instruction sequencing.

---
 rtl/instr_issuer_if.sv | 41 ++++
 rtl/instr_issuer.sv | 223 ++++++++++++++++++++++
 tb/tb_instr_issuer.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_issuer_if.sv
//----------------------------------------------------------------------------
// instr_issuer_if
//
// Bundle of the signals between the instruction issuer, its program loader,
// and the datapath decoder/control pair.
//
//   Program load : LoadEn, LoadAddr[AW-1:0], LoadData[15:0]
//   Run control  : Run, Len[AW:0], Busy, Done, Err
//   Datapath     : Instr[15:0], START (issuer -> control), RDY (control -> issuer)
//   Debug        : PC[AW-1:0]
//
// Modports:
//   master - the issuer itself (drives Instr/START/status, receives the rest)
//   slave  - the environment: loader, run controller and datapath control
//----------------------------------------------------------------------------
interface instr_issuer_if #(
    parameter int AW = 4
);
    logic          LoadEn;
    logic [AW-1:0] LoadAddr;
    logic [15:0]   LoadData;
    logic          Run;
    logic [AW:0]   Len;
    logic          RDY;
    logic [15:0]   Instr;
    logic          START;
    logic [AW-1:0] PC;
    logic          Busy;
    logic          Done;
    logic          Err;

    modport master (
        input  LoadEn, LoadAddr, LoadData, Run, Len, RDY,
        output Instr, START, PC, Busy, Done, Err
    );

    modport slave (
        output LoadEn, LoadAddr, LoadData, Run, Len, RDY,
        input  Instr, START, PC, Busy, Done, Err
    );
endinterface

// File: rtl/instr_issuer.sv
//----------------------------------------------------------------------------
// instr_issuer
//
// Holds a small loadable program store and feeds it, one 16-bit instruction
// at a time, into the datapath decoder/control pair over a START/RDY
// four-phase handshake. Each instruction is presented on Instr with START
// high; the issuer waits for RDY high (instruction accepted/complete), drops
// START, then waits for RDY low before fetching the next word.
//
// Ports:
//   CLK   - single clock, rising edge
//   RST   - asynchronous, active-high reset (program memory is retained)
//   bus   - instr_issuer_if.master:
//             LoadEn/LoadAddr/LoadData  program write, honoured only in IDLE
//             Run/Len                   start at address 0, run min(Len,DEPTH)
//             RDY                       completion from datapath control
//             Instr/START               instruction and issue request
//             PC                        address of the current instruction
//             Busy/Done/Err             run status, one-cycle Done pulse,
//                                       sticky timeout flag
//
// Parameters:
//   DEPTH   - number of program words (must equal 2**AW)
//   AW      - program address width
//   TIMEOUT - cycles allowed per handshake phase (ISSUE or RELEASE)
//
// Build option:
//   ISSUER_TIMEOUT_EN - when defined, a phase that waits TIMEOUT cycles for RDY
//                       is abandoned: START drops, Err is set and the run ends
//                       with a Done pulse. When undefined, Err is constant 0
//                       and the issuer waits for RDY indefinitely.
//----------------------------------------------------------------------------
module instr_issuer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           CLK,
    input  logic           RST,
    instr_issuer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_RELEASE,
        S_DONE
    } state_e;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    //------------------------------------------------------------------------
    // Program store
    //------------------------------------------------------------------------
    logic [15:0] mem [DEPTH];
    logic        mem_we;

    // NOTE: the program store has no reset on purpose; a loaded program must
    // survive RST, and leaving it out of reset lets it map onto plain RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[bus.LoadAddr] <= bus.LoadData;
        end
    end

    //------------------------------------------------------------------------
    // State and datapath registers
    //------------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [AW-1:0] pc_q,    pc_d;
    logic [AW:0]   n_q,     n_d;      // instruction count of the current run
    logic [15:0]   instr_q, instr_d;
    logic          start_q, start_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;
    logic          err_q,   err_d;

    logic [AW:0]   len_clamped;
    logic          last_instr;
    logic          timeout_hit;

    assign len_clamped = (bus.Len > DEPTH_W) ? DEPTH_W : bus.Len;
    assign last_instr  = ({1'b0, pc_q} == (n_q - 1'b1));

    //------------------------------------------------------------------------
    // Handshake phase watchdog
    //------------------------------------------------------------------------
`ifdef ISSUER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_wait_phase;

    assign in_wait_phase = (state_q == S_ISSUE) || (state_q == S_RELEASE);

    // Restart on every state change so ISSUE and RELEASE each get a full
    // TIMEOUT budget; the count is the number of edges spent in the phase.
    assign tmo_d = (in_wait_phase && (state_d == state_q)) ? tmo_q + 1'b1 : '0;

    // Counter value TIMEOUT-1 means this edge is the TIMEOUT-th in the phase.
    assign timeout_hit = in_wait_phase && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    // NOTE: every signal written here gets its default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        n_d     = n_q;
        instr_d = instr_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A write and a Run in the same cycle both take effect: the
                // word lands on this edge and FETCH reads it one edge later.
                mem_we = bus.LoadEn;
                if (bus.Run) begin
                    n_d     = len_clamped;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = (len_clamped == '0) ? S_DONE : S_FETCH;
                end
            end

            S_FETCH: begin
                instr_d = mem[pc_q];
                state_d = S_ISSUE;
            end

            S_ISSUE: begin
                if (bus.RDY) begin
                    state_d = S_RELEASE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_RELEASE: begin
                if (!bus.RDY) begin
                    if (last_instr) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered and follow the state being entered,
        // so START/Busy/Done are glitch-free and line up with the state.
        start_d = (state_d == S_ISSUE);
        busy_d  = (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                  (state_d == S_RELEASE);
        done_d  = (state_d == S_DONE);
    end

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            n_q     <= '0;
            instr_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            n_q     <= n_d;
            instr_q <= instr_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    //------------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------------
    assign bus.Instr = instr_q;
    assign bus.START = start_q;
    assign bus.PC    = pc_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.Err   = err_q;

endmodule

// File: tb/tb_instr_issuer.sv
//----------------------------------------------------------------------------
// tb_instr_issuer
//
// Self-checking bench for instr_issuer. A datapath responder answers START
// with RDY (fixed or random delays), a monitor logs every issued instruction
// and Done pulse, and a program-level reference model (array of loaded words
// plus the rule "issue words 0..min(Len,DEPTH)-1 in order") supplies the
// expected sequences. Outputs are sampled on the falling clock edge.
//----------------------------------------------------------------------------
module tb_instr_issuer;

    localparam int DEPTH   = 16;
    localparam int AW      = 4;
    localparam int TIMEOUT = 8;

    localparam logic [15:0] BASIC [3] = '{16'h5001, 16'h61F2, 16'h4001};

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_issuer_if #(.AW(AW)) bus ();

    instr_issuer #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the program as the bench believes it was loaded.
    logic [15:0] model_mem [DEPTH];

    // Monitor log for the current run.
    logic [15:0] iss_instr [$];
    int          iss_pc    [$];
    int          done_cnt;
    int          done_pc;

    // Responder control.
    bit rsp_en   = 1'b0;
    bit rsp_rand = 1'b0;
    int rise_dly = 3;
    int hold_dly = 1;

    //------------------------------------------------------------------------
    // Monitor: logs issues and Done pulses, checks Instr stability.
    //------------------------------------------------------------------------
    initial begin : monitor
        logic        start_prev;
        logic [15:0] held;
        start_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                start_prev = 1'b0;
            end else begin
                if (bus.START === 1'b1 && !start_prev) begin
                    iss_instr.push_back(bus.Instr);
                    iss_pc.push_back(int'(bus.PC));
                    held = bus.Instr;
                end else if (bus.START === 1'b1) begin
                    n_cmp++;
                    if (bus.Instr !== held) begin
                        n_bad++;
                        $display("FAIL instr_stable: Instr=%h while START high, held=%h", bus.Instr, held);
                    end
                end
                if (bus.Done === 1'b1) begin
                    done_cnt++;
                    done_pc = int'(bus.PC);
                    n_cmp++;
                    if (bus.Busy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL done_busy: Busy=%b during Done, want 0", bus.Busy);
                    end
                end
                start_prev = (bus.START === 1'b1);
            end
        end
    end

    //------------------------------------------------------------------------
    // Datapath responder: RDY rises some cycles after START, falls some
    // cycles after START drops.
    //------------------------------------------------------------------------
    initial begin : responder
        int phase;
        int cnt;
        phase  = 0;
        cnt    = 0;
        bus.RDY = 1'b0;
        forever begin
            @(negedge clk);
            if (!rsp_en) begin
                phase = 0;
            end else if (rst) begin
                bus.RDY = 1'b0;
                phase   = 0;
            end else begin
                if (phase == 0 && bus.START === 1'b1) begin
                    cnt   = rsp_rand ? int'($urandom_range(4, 0)) : rise_dly;
                    phase = 1;
                end
                if (phase == 1) begin
                    if (cnt == 0) begin
                        bus.RDY = 1'b1;
                        phase   = 2;
                    end else begin
                        cnt--;
                    end
                end
                if (phase == 2 && bus.START === 1'b0) begin
                    cnt   = rsp_rand ? int'($urandom_range(4, 0)) : hold_dly;
                    phase = 3;
                end
                if (phase == 3) begin
                    if (cnt == 0) begin
                        bus.RDY = 1'b0;
                        phase   = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // Stimulus helpers
    //------------------------------------------------------------------------
    task automatic load_word(input int a, input logic [15:0] d);
        @(negedge clk);
        bus.LoadEn   = 1'b1;
        bus.LoadAddr = AW'(a);
        bus.LoadData = d;
        model_mem[a] = d;
        @(negedge clk);
        bus.LoadEn   = 1'b0;
    endtask

    task automatic start_run(input int len);
        iss_instr.delete();
        iss_pc.delete();
        done_cnt = 0;
        done_pc  = -1;
        @(negedge clk);
        bus.Run = 1'b1;
        bus.Len = (AW+1)'(len);
        @(negedge clk);
        bus.Run = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (done_cnt == 0) begin
            n_bad++;
            $display("FAIL %s_done_wait: no Done within %0d cycles", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input string name, input logic level, input int budget);
        int k = 0;
        while (bus.START !== level && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus.START !== level) begin
            n_bad++;
            $display("FAIL %s: START=%b after %0d cycles, want %b", name, bus.START, budget, level);
        end
    endtask

    //------------------------------------------------------------------------
    // Tests
    //------------------------------------------------------------------------
    task automatic test_reset();
        logic [21:0] got;
        rst          = 1'b1;
        bus.LoadEn   = 1'b0;
        bus.LoadAddr = '0;
        bus.LoadData = '0;
        bus.Run      = 1'b0;
        bus.Len      = '0;
        repeat (3) @(negedge clk);
        got = {bus.Instr, bus.START, bus.PC, bus.Busy};
        n_cmp++;
        if (got !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: Instr/START/PC/Busy=%h, want 0", got);
        end
        n_cmp++;
        if (bus.Done !== 1'b0 || bus.Err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_status: Done=%b Err=%b, want 0 0", bus.Done, bus.Err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_program(input bit do_load);
        rsp_en   = 1'b1;
        rsp_rand = 1'b0;
        rise_dly = 3;
        hold_dly = 1;
        if (do_load) begin
            for (int i = 0; i < 3; i++) load_word(i, BASIC[i]);
        end
        start_run(3);
        wait_done("basic", 200);
        n_cmp++;
        if (iss_instr.size() != 3) begin
            n_bad++;
            $display("FAIL basic_count: %0d issues, want 3", iss_instr.size());
        end
        for (int i = 0; i < 3 && i < iss_instr.size(); i++) begin
            n_cmp++;
            if (iss_instr[i] !== BASIC[i] || iss_pc[i] != i) begin
                n_bad++;
                $display("FAIL basic_issue%0d: Instr=%h PC=%0d, want %h PC=%0d",
                         i, iss_instr[i], iss_pc[i], BASIC[i], i);
            end
        end
        n_cmp++;
        if (done_cnt != 1 || done_pc != 2) begin
            n_bad++;
            $display("FAIL basic_done: pulses=%0d PC=%0d, want 1 pulse at PC=2", done_cnt, done_pc);
        end
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_after: Busy=%b, want 0", bus.Busy);
        end
    endtask

    task automatic test_len_zero();
        iss_instr.delete();
        iss_pc.delete();
        @(negedge clk);
        bus.Run = 1'b1;
        bus.Len = '0;
        @(negedge clk);
        bus.Run = 1'b0;
        n_cmp++;
        if (bus.Done !== 1'b1) begin
            n_bad++;
            $display("FAIL len0_done: Done=%b one edge after Run, want 1", bus.Done);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.Done !== 1'b0) begin
            n_bad++;
            $display("FAIL len0_pulse: Done=%b second cycle, want 0", bus.Done);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (iss_instr.size() != 0) begin
            n_bad++;
            $display("FAIL len0_start: %0d issues, want 0", iss_instr.size());
        end
    endtask

    task automatic test_clamp();
        rsp_en   = 1'b1;
        rsp_rand = 1'b0;
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom));
        start_run(20);
        wait_done("clamp", 1000);
        n_cmp++;
        if (iss_instr.size() != DEPTH) begin
            n_bad++;
            $display("FAIL clamp_count: %0d issues, want %0d", iss_instr.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH && i < iss_instr.size(); i++) begin
            n_cmp++;
            if (iss_instr[i] !== model_mem[i] || iss_pc[i] != i) begin
                n_bad++;
                $display("FAIL clamp_issue%0d: Instr=%h PC=%0d, want %h PC=%0d",
                         i, iss_instr[i], iss_pc[i], model_mem[i], i);
            end
        end
        n_cmp++;
        if (done_pc != DEPTH - 1) begin
            n_bad++;
            $display("FAIL clamp_done_pc: PC=%0d, want %0d", done_pc, DEPTH - 1);
        end
    endtask

    task automatic test_random_runs();
        rsp_en   = 1'b1;
        rsp_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int len;
            int n;
            int bad;
            repeat (2) load_word(int'($urandom_range(DEPTH - 1, 0)), 16'($urandom));
            len = int'($urandom_range(31, 0));
            n   = (len > DEPTH) ? DEPTH : len;
            start_run(len);
            wait_done("random", 1000);
            bad = 0;
            for (int i = 0; i < n && i < iss_instr.size(); i++) begin
                if (iss_instr[i] !== model_mem[i] || iss_pc[i] != i) bad++;
            end
            n_cmp++;
            if (iss_instr.size() != n || bad != 0 || done_cnt != 1) begin
                n_bad++;
                $display("FAIL random_run%0d: Len=%0d issues=%0d wrong=%0d done=%0d, want %0d issues 0 wrong 1 done",
                         r, len, iss_instr.size(), bad, done_cnt, n);
            end
        end
        rsp_rand = 1'b0;
    endtask

    task automatic test_busy_lockout();
        rsp_en = 1'b1;
        for (int i = 0; i < 3; i++) load_word(i, BASIC[i]);
        start_run(3);
        wait_start("lockout_start", 1'b1, 20);
        @(negedge clk);
        bus.Run      = 1'b1;
        bus.Len      = 5'd5;
        bus.LoadEn   = 1'b1;
        bus.LoadAddr = AW'(1);
        bus.LoadData = 16'hFFFF;
        @(negedge clk);
        bus.Run      = 1'b0;
        bus.LoadEn   = 1'b0;
        wait_done("lockout", 200);
        n_cmp++;
        if (iss_instr.size() != 3 || iss_instr[0] !== BASIC[0] ||
            iss_instr[1] !== BASIC[1] || iss_instr[2] !== BASIC[2]) begin
            n_bad++;
            $display("FAIL lockout_seq: %0d issues, want 3 matching 5001 61F2 4001", iss_instr.size());
        end
        start_run(3);
        wait_done("lockout_rerun", 200);
        n_cmp++;
        if (iss_instr.size() < 2 || iss_instr[1] !== 16'h61F2 || iss_pc[1] != 1) begin
            n_bad++;
            $display("FAIL lockout_rerun: issues=%0d second=%h, want 61F2 at PC=1",
                     iss_instr.size(), (iss_instr.size() > 1) ? iss_instr[1] : 16'h0);
        end
    endtask

    task automatic test_slow_release();
        int k;
        rsp_en  = 1'b0;
        bus.RDY = 1'b0;
        start_run(2);
        wait_start("slow_first_start", 1'b1, 20);
        repeat (2) @(negedge clk);
        bus.RDY = 1'b1;
        wait_start("slow_start_fall", 1'b0, 5);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus.START !== 1'b0 || bus.Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL slow_hold: START=%b Busy=%b while RDY held, want 0 1", bus.START, bus.Busy);
        end
        bus.RDY = 1'b0;
        k = 0;
        while (bus.START !== 1'b1 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (k != 2) begin
            n_bad++;
            $display("FAIL slow_restart: START rose %0d edges after RDY low, want 2", k);
        end
        n_cmp++;
        if (bus.Instr !== model_mem[1] || bus.PC !== AW'(1)) begin
            n_bad++;
            $display("FAIL slow_second: Instr=%h PC=%0d, want %h PC=1", bus.Instr, bus.PC, model_mem[1]);
        end
        @(negedge clk);
        bus.RDY = 1'b1;
        wait_start("slow_second_fall", 1'b0, 5);
        bus.RDY = 1'b0;
        wait_done("slow", 20);
        rsp_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int k;
        rsp_en = 1'b1;
        start_run(3);
        k = 0;
        while (!(iss_instr.size() == 2 && bus.START === 1'b1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus.START !== 1'b1 || bus.PC !== AW'(1)) begin
            n_bad++;
            $display("FAIL rstmid_reach: START=%b PC=%0d, want 1 at PC=1", bus.START, bus.PC);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.START !== 1'b0 || bus.Busy !== 1'b0 || bus.PC !== '0 || bus.Done !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async: START=%b Busy=%b PC=%0d Done=%b, want all 0",
                     bus.START, bus.Busy, bus.PC, bus.Done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_basic_program(1'b0);
    endtask

    task automatic test_timeout();
        int k;
        rsp_en  = 1'b0;
        bus.RDY = 1'b0;
        start_run(2);
        wait_start("tmo_start", 1'b1, 20);
`ifdef ISSUER_TIMEOUT_EN
        k = 0;
        while (bus.START === 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k != TIMEOUT) begin
            n_bad++;
            $display("FAIL tmo_len: START high %0d cycles, want %0d", k, TIMEOUT);
        end
        n_cmp++;
        if (bus.Err !== 1'b1 || bus.Done !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_flag: Err=%b Done=%b at START fall, want 1 1", bus.Err, bus.Done);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.Err !== 1'b1 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL tmo_sticky: Err=%b done pulses=%0d, want 1 and 1", bus.Err, done_cnt);
        end
        @(negedge clk);
        bus.Run = 1'b1;
        bus.Len = '0;
        @(negedge clk);
        bus.Run = 1'b0;
        n_cmp++;
        if (bus.Err !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_clear: Err=%b after next Run, want 0", bus.Err);
        end
        repeat (2) @(negedge clk);
`else
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.START !== 1'b1 || bus.Err !== 1'b0) k++;
        end
        n_cmp++;
        if (k != 0) begin
            n_bad++;
            $display("FAIL notmo_wait: %0d of 100 cycles with START!=1 or Err!=0, want 0", k);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        rsp_en = 1'b1;
    endtask

    //------------------------------------------------------------------------
    // Sequence
    //------------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic_program(1'b1);
        test_len_zero();
        test_clamp();
        test_random_runs();
        test_busy_lockout();
        test_slow_release();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
